// File: rtl/uart_pkg.sv
// Shared UART definitions for the byte transmit and receive paths.
// Line levels, payload width and the transmit FSM state encoding.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// clear holds the count at zero so a new frame starts on a full period.
module baud_tick #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap after the last cycle of a bit, or hold at zero.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// UART 8N1 byte transmitter with a one-entry holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] Tx_byte,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    import uart_pkg::*;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic hold_full_q, hold_full_d;
    logic serial_q, serial_d;
    logic load;
    logic clear;
    logic tick;

    assign clear = (state_q == IDLE);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    // Next state, holding register handshake and the next line level.
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;
        serial_d    = IDLE_LEVEL;

        // Accept only into an empty holding register; this never
        // coincides with a drain, which needs the register full.
        if (tx_valid && !hold_full_q) begin
            hold_d      = Tx_byte;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
        end

        // Line level follows the state being entered so it is registered.
        unique case (state_d)
            IDLE:    serial_d = IDLE_LEVEL;
            START:   serial_d = START_LEVEL;
            DATA:    serial_d = shift_d[bit_d];
            PARITY:  serial_d = ^shift_d;
            STOP:    serial_d = STOP_LEVEL;
            default: serial_d = IDLE_LEVEL;
        endcase
    end

    // State, counters, data registers and the registered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            serial_q    <= IDLE_LEVEL;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            serial_q    <= serial_d;
        end
    end

    assign tx_ready  = !hold_full_q;
    assign tx_serial = serial_q;
    assign tx_busy   = (state_q != IDLE);
    assign tx_done   = (state_q == STOP) && tick;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx at CLKS_PER_BIT=4.
// A monitor captures each frame from the line and checks it against the queue.
module tb_uart_byte_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] Tx_byte = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    uart_byte_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Tx_byte  (Tx_byte),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_serial(tx_serial),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    int starts[$];
    bit mon_en = 1'b0;

    logic [FL-1:0] ser, dn, bs, ser_e, dn_e;
    logic [NB-1:0] fb;
    logic [7:0] mb;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line bit sequence, index 0 first on the wire.
    function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
        logic [NB-1:0] f;
        f = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] b, input bit track,
                        output int acc);
        int n;
        n = 0;
        Tx_byte  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            chk("send_timeout", 64'd0, 64'd1);
            tx_valid = 1'b0;
            acc = -1;
            return;
        end
        @(negedge clk);
        acc = cyc;
        tx_valid = 1'b0;
        if (track) exp_q.push_back(b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((tx_busy !== 1'b0 || exp_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: capture one whole frame from its first low cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && tx_serial === 1'b0) begin
                starts.push_back(cyc);
                for (int i = 0; i < FL; i++) begin
                    if (i > 0) @(negedge clk);
                    ser[i] = tx_serial;
                    dn[i]  = tx_done;
                    bs[i]  = tx_busy;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 64'(ser), 64'd0);
                end else begin
                    mb = exp_q.pop_front();
                    fb = frame_bits(mb);
                    for (int i = 0; i < FL; i++) ser_e[i] = fb[i / CPB];
                    dn_e = '0;
                    dn_e[FL-1] = 1'b1;
                    chk("frame_serial", 64'(ser), 64'(ser_e));
                    chk("frame_done", 64'(dn), 64'(dn_e));
                    chk("frame_busy", 64'(bs), 64'({FL{1'b1}}));
                end
            end
        end
    end

    int acc, acc2, bad;

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_serial", 64'(tx_serial), 64'd1);
        chk("rst_busy", 64'(tx_busy), 64'd0);
        chk("rst_ready", 64'(tx_ready), 64'd1);
        chk("rst_done", 64'(tx_done), 64'd0);
        rst = 1'b0;

        // Reset in the middle of a frame with a byte held.
        send(8'hA5, 1'b0, acc);
        send(8'h3C, 1'b0, acc2);
        repeat (10) @(negedge clk);
        chk("held_full", 64'(tx_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_serial", 64'(tx_serial), 64'd1);
        chk("midrst_busy", 64'(tx_busy), 64'd0);
        chk("midrst_ready", 64'(tx_ready), 64'd1);
        chk("midrst_done", 64'(tx_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("rst_discard", 64'(bad), 64'd0);
        mon_en = 1'b1;

        // Single byte, direct path latency.
        starts.delete();
        send(8'h41, 1'b1, acc);
        wait_idle();
        if (starts.size() > 0)
            chk("start_latency", 64'(starts[0] - acc), 64'd1);
        else
            chk("start_seen", 64'd0, 64'd1);

        // Back-to-back with backpressure on a third byte.
        starts.delete();
        send(8'h41, 1'b1, acc);
        send(8'h5A, 1'b1, acc2);
        chk("ready_drop", 64'(tx_ready), 64'd0);
        Tx_byte  = 8'hC3;
        tx_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_ready !== 1'b0) bad++;
        end
        chk("backpressure", 64'(bad), 64'd0);
        send(8'hC3, 1'b1, acc2);
        wait_idle();
        chk("b2b_frames", 64'(starts.size()), 64'd3);
        if (starts.size() == 3) begin
            chk("gap_1_2", 64'(starts[1] - starts[0]), 64'(FL));
            chk("gap_2_3", 64'(starts[2] - starts[1]), 64'(FL));
        end

`ifdef UART_TX_PARITY_EN
        send(8'h43, 1'b1, acc);
        wait_idle();
`endif

        // Long idle stretch.
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0 ||
                tx_done !== 1'b0) bad++;
        end
        chk("idle_line", 64'(bad), 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
